// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline-stage register: state encoding derived
// from the (main valid, skid valid) pair, default widths and counter width.
package pipe_pkg;

  localparam int DEF_DATA_W = 96;
  localparam int DEF_CTRL_W = 12;
  localparam int STATS_W    = 32;

  // Encoding is literally {m_valid, s_valid}; 2'b01 can never be legal.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready stage link carrying a payload and a control bundle.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CTRL_W = DEF_CTRL_W
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with enable; sticks at all-ones.
module pipe_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: increment only while enabled and not yet saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_chk.sv
// Invariant checker for the skid stage: the skid entry is never occupied
// while the main entry is empty.
module pipe_stage_skid_chk (
  input logic clk,
  input logic rst_n,
  input logic m_valid,
  input logic s_valid
);

  a_no_orphan_skid: assert property (@(posedge clk) disable iff (!rst_n)
    !(s_valid && !m_valid));

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with 2-entry skid buffer and flush.
// Optional PIPE_STAGE_STATS_EN adds saturating stall/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                CTRL_W     = DEF_CTRL_W,
  parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  pipe_stage_skid_if.slave    up,
  pipe_stage_skid_if.master   dn
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [STATS_W-1:0]  stall_cnt,
  output logic [STATS_W-1:0]  bubble_cnt
`endif
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;

  logic        in_fire_s;
  logic        out_fire_s;
  pipe_state_e state_s;

  assign state_s    = pipe_state_e'({m_valid_q, s_valid_q});
  assign in_fire_s  = up.valid & ~s_valid_q;
  assign out_fire_s = m_valid_q & dn.ready;

  // Next-state for both entries; ctrl is cleared whenever an entry empties.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_ctrl_d  = m_ctrl_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    s_ctrl_d  = s_ctrl_q;
    if (flush) begin
      m_valid_d = 1'b0;
      m_data_d  = RESET_DATA;
      m_ctrl_d  = {CTRL_W{1'b0}};
      s_valid_d = 1'b0;
      s_data_d  = RESET_DATA;
      s_ctrl_d  = {CTRL_W{1'b0}};
    end else begin
      case (state_s)
        ST_EMPTY: begin
          if (in_fire_s) begin
            m_valid_d = 1'b1;
            m_data_d  = up.data;
            m_ctrl_d  = up.ctrl;
          end else begin
            m_valid_d = 1'b0;
          end
        end
        ST_BUSY: begin
          if (in_fire_s && out_fire_s) begin
            m_data_d = up.data;
            m_ctrl_d = up.ctrl;
          end else if (in_fire_s) begin
            s_valid_d = 1'b1;
            s_data_d  = up.data;
            s_ctrl_d  = up.ctrl;
          end else if (out_fire_s) begin
            m_valid_d = 1'b0;
            m_ctrl_d  = {CTRL_W{1'b0}};
          end else begin
            m_valid_d = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            m_data_d  = s_data_q;
            m_ctrl_d  = s_ctrl_q;
            s_valid_d = 1'b0;
            s_ctrl_d  = {CTRL_W{1'b0}};
          end else begin
            s_valid_d = 1'b1;
          end
        end
        default: begin
          // Orphaned skid entry: drop everything rather than emit it out of order.
          m_valid_d = 1'b0;
          m_ctrl_d  = {CTRL_W{1'b0}};
          s_valid_d = 1'b0;
          s_ctrl_d  = {CTRL_W{1'b0}};
        end
      endcase
    end
  end

  // Main and skid entry registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      m_data_q  <= RESET_DATA;
      m_ctrl_q  <= {CTRL_W{1'b0}};
      s_valid_q <= 1'b0;
      s_data_q  <= RESET_DATA;
      s_ctrl_q  <= {CTRL_W{1'b0}};
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_ctrl_q  <= m_ctrl_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
      s_ctrl_q  <= s_ctrl_d;
    end
  end

  assign up.ready = ~s_valid_q;
  assign dn.valid = m_valid_q;
  assign dn.data  = m_data_q;
  assign dn.ctrl  = m_ctrl_q;

  pipe_stage_skid_chk u_chk (
    .clk     (clk),
    .rst_n   (reset),
    .m_valid (m_valid_q),
    .s_valid (s_valid_q)
  );

`ifdef PIPE_STAGE_STATS_EN
  logic stall_en_s;
  logic bubble_en_s;

  assign stall_en_s  = m_valid_q & ~dn.ready;
  assign bubble_en_s = dn.ready & ~m_valid_q;

  pipe_sat_cnt #(.W(STATS_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (stall_en_s),
    .cnt   (stall_cnt)
  );

  pipe_sat_cnt #(.W(STATS_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (reset),
    .en    (bubble_en_s),
    .cnt   (bubble_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed steps plus random traffic
// checked against a queue model of a 2-deep FIFO stage.
module tb_pipe_stage_skid;

  localparam int          DW   = 16;
  localparam int          CW   = 4;
  localparam logic [15:0] RDAT = 16'hA5A5;

  logic clk;
  logic reset;
  logic flush;
  logic sc_en;
  logic [2:0] sc_cnt;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up_if ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn_if ();

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .RESET_DATA(RDAT)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .up    (up_if.slave),
    .dn    (dn_if.master)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  pipe_sat_cnt #(.W(3)) u_sat (
    .clk   (clk),
    .rst_n (reset),
    .en    (sc_en),
    .cnt   (sc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: stage behaves as a FIFO of capacity 2 whose head is the output.
  logic [19:0] mq[$];
  logic [31:0] exp_stall  = 32'd0;
  logic [31:0] exp_bubble = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_stall  = 32'd0;
    exp_bubble = 32'd0;
  endtask

  task automatic model_edge(input logic v, input logic [15:0] d, input logic [3:0] c,
                            input logic r, input logic f);
    int  sz;
    bit  inf;
    bit  outf;
    sz   = mq.size();
    inf  = v && (sz < 2);
    outf = (sz > 0) && r;
    if ((sz > 0) && !r && (exp_stall != 32'hFFFF_FFFF)) exp_stall++;
    if ((sz == 0) && r && (exp_bubble != 32'hFFFF_FFFF)) exp_bubble++;
    if (f) begin
      mq.delete();
    end else begin
      if (outf) void'(mq.pop_front());
      if (inf) mq.push_back({d, c});
    end
  endtask

  task automatic check_all();
    logic [19:0] head;
    chk("out_valid", 32'(dn_if.valid), 32'(mq.size() > 0));
    chk("in_ready", 32'(up_if.ready), 32'(mq.size() < 2));
    if (mq.size() > 0) begin
      head = mq[0];
      chk("out_data", 32'(dn_if.data), 32'(head[19:4]));
      chk("out_ctrl", 32'(dn_if.ctrl), 32'(head[3:0]));
    end else begin
      chk("out_ctrl_idle", 32'(dn_if.ctrl), 32'd0);
    end
`ifdef PIPE_STAGE_STATS_EN
    chk("stall_cnt", stall_cnt, exp_stall);
    chk("bubble_cnt", bubble_cnt, exp_bubble);
`endif
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic [3:0] c,
                      input logic r, input logic f);
    up_if.valid = v;
    up_if.data  = d;
    up_if.ctrl  = c;
    dn_if.ready = r;
    flush       = f;
    @(posedge clk);
    model_edge(v, d, c, r, f);
    @(negedge clk);
    check_all();
  endtask

  task automatic apply_reset();
    up_if.valid = 1'b0;
    dn_if.ready = 1'b0;
    flush       = 1'b0;
    reset       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    model_clear();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v;
    logic r;
    logic f;
    int   exp_sc;

    // Reset held with upstream trying to push.
    reset       = 1'b0;
    flush       = 1'b0;
    sc_en       = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 16'h0077;
    up_if.ctrl  = 4'hF;
    dn_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
    chk("rst_out_ctrl", 32'(dn_if.ctrl), 32'd0);
    chk("rst_out_data", 32'(dn_if.data), 32'(RDAT));
    chk("rst_in_ready", 32'(up_if.ready), 32'd1);
    chk("rst_sat_cnt", 32'(sc_cnt), 32'd0);
    model_clear();
    reset = 1'b1;

    // First transfer: one-cycle latency.
    step(1'b1, 16'h0123, 4'h3, 1'b1, 1'b0);
    chk("first_data", 32'(dn_if.data), 32'h0123);

    // Streaming 1..8 with no gaps.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'(i), 4'(i), 1'b1, 1'b0);
      chk("stream_data", 32'(dn_if.data), 32'(i));
      chk("stream_ready", 32'(up_if.ready), 32'd1);
    end
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);

    // Backpressure: 1 main, 2 skid, 3 refused until drained.
    step(1'b1, 16'h0001, 4'h1, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 4'h2, 1'b0, 1'b0);
    step(1'b1, 16'h0003, 4'h3, 1'b0, 1'b0);
    chk("bp_in_ready", 32'(up_if.ready), 32'd0);
    chk("bp_hold_data", 32'(dn_if.data), 32'h0001);
    step(1'b1, 16'h0003, 4'h3, 1'b1, 1'b0);
    chk("bp_second", 32'(dn_if.data), 32'h0002);
    step(1'b1, 16'h0003, 4'h3, 1'b1, 1'b0);
    chk("bp_third", 32'(dn_if.data), 32'h0003);
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);

    // Flush while FULL, with a competing push of 9.
    step(1'b1, 16'h0004, 4'h4, 1'b0, 1'b0);
    step(1'b1, 16'h0005, 4'h5, 1'b0, 1'b0);
    step(1'b1, 16'h0009, 4'h9, 1'b0, 1'b1);
    chk("flush_valid", 32'(dn_if.valid), 32'd0);
    chk("flush_ctrl", 32'(dn_if.ctrl), 32'd0);
    chk("flush_ready", 32'(up_if.ready), 32'd1);
    chk("flush_data", 32'(dn_if.data), 32'(RDAT));
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a cycle while FULL.
    step(1'b1, 16'h00AA, 4'hA, 1'b0, 1'b0);
    step(1'b1, 16'h00BB, 4'hB, 1'b0, 1'b0);
    up_if.valid = 1'b0;
    dn_if.ready = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(dn_if.valid), 32'd0);
    chk("arst_ctrl", 32'(dn_if.ctrl), 32'd0);
    chk("arst_data", 32'(dn_if.data), 32'(RDAT));
    chk("arst_ready", 32'(up_if.ready), 32'd1);
    @(negedge clk);
    model_clear();
    reset = 1'b1;

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 15) == 0);
      step(v, 16'($urandom), 4'($urandom), r, f);
    end

    // Saturating counter: 3-bit instance sticks at 7.
    apply_reset();
    for (int i = 1; i <= 10; i++) begin
      sc_en = 1'b1;
      step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
      exp_sc = (i > 7) ? 7 : i;
      chk("sat_cnt", 32'(sc_cnt), 32'(exp_sc));
    end
    sc_en = 1'b0;
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    chk("sat_hold", 32'(sc_cnt), 32'd7);

    // Five stall cycles then three bubble cycles from a fresh reset.
    apply_reset();
    step(1'b1, 16'h0055, 4'h1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 16'h0000, 4'h0, 1'b1, 1'b0);
`ifdef PIPE_STAGE_STATS_EN
    chk("stats_stall5", stall_cnt, 32'd5);
    chk("stats_bubble3", bubble_cnt, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
